// File: rtl/ul_normalizer_pkg.sv
// ============================================================================
// Module   : ul_normalizer_pkg
// Brief    : Shared FPU datapath defaults and helpers for the normalizer.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ul_normalizer_pkg;

    localparam int FP_MANT_W = 32;
    localparam int FP_EXP_W  = 9;

    typedef enum logic [1:0] {
        RES_NORMAL = 2'd0,
        RES_DENORM = 2'd1,
        RES_ZERO   = 2'd2
    } res_class_e;

    // Width of a leading-zero count for a w-bit word (must also hold the value w).
    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ul_normalizer_shifter.sv
// ============================================================================
// Module   : ul_normalizer_shifter
// Brief    : Combinational log2(W)-stage barrel left shifter, zero when shift >= W.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ul_normalizer_shifter #(
    parameter int W   = 32,
    parameter int LZW = 6
) (
    input  logic [W-1:0]   i_data,
    input  logic [LZW-1:0] i_shift,
    output logic [W-1:0]   o_data
);

    localparam int SW = $clog2(W);

    logic [W-1:0] w_stage [0:SW];

    assign w_stage[0] = i_data;

    generate
        for (genvar k = 0; k < SW; k++) begin : g_stage
            assign w_stage[k+1] = i_shift[k] ? (w_stage[k] << (1 << k)) : w_stage[k];
        end
    endgenerate

    // Any shift bit at or above log2(W) means the whole word is shifted out.
    assign o_data = (|i_shift[LZW-1:SW]) ? '0 : w_stage[SW];

endmodule

`default_nettype wire

// File: rtl/ul_normalizer.sv
// ============================================================================
// Module   : ul_normalizer
// Brief    : 2-stage pipelined mantissa normalizer with denormal clamping.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

import ul_normalizer_pkg::*;

module ul_normalizer #(
    parameter int W     = FP_MANT_W,
    parameter int EXP_W = FP_EXP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm
);

    localparam int LZW = lzc_width(W);
    localparam int CW  = (EXP_W > LZW) ? EXP_W : LZW;

    logic             valid_s1_q, valid_s1_d;
    logic [W-1:0]     mant_s1_q,  mant_s1_d;
    logic [EXP_W-1:0] exp_s1_q,   exp_s1_d;
    logic [LZW-1:0]   lzc_s1_q,   lzc_s1_d;

    logic             valid_s2_q,  valid_s2_d;
    logic [W-1:0]     mant_s2_q,   mant_s2_d;
    logic [EXP_W-1:0] exp_s2_q,    exp_s2_d;
    logic             zero_s2_q,   zero_s2_d;
    logic             denorm_s2_q, denorm_s2_d;

    logic             w_en_s1;
    logic             w_en_s2;
    logic [LZW-1:0]   w_lzc;
    logic [EXP_W-1:0] w_exp_m1;
    logic [LZW-1:0]   w_shift;
    logic [W-1:0]     w_shifted;
    res_class_e       w_class;

    assign w_en_s2  = !valid_s2_q || out_ready;
    assign w_en_s1  = !valid_s1_q || w_en_s2;
    assign in_ready = w_en_s1;

    // Priority encoder: the highest set bit is visited last and wins.
    always_comb begin
        w_lzc = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (in_mant[i]) begin
                w_lzc = LZW'(W - 1 - i);
            end
        end
    end

    always_comb begin
        w_exp_m1 = exp_s1_q - EXP_W'(1);
        w_shift  = '0;
        if (exp_s1_q != '0) begin
            if (CW'(lzc_s1_q) <= CW'(w_exp_m1)) begin
                w_shift = lzc_s1_q;
            end else begin
                // Clamp: here exp-1 < lzc <= W, so it fits in LZW bits.
                w_shift = LZW'(w_exp_m1);
            end
        end
    end

    ul_normalizer_shifter #(
        .W   (W),
        .LZW (LZW)
    ) u_shifter (
        .i_data  (mant_s1_q),
        .i_shift (w_shift),
        .o_data  (w_shifted)
    );

    always_comb begin
        if (mant_s1_q == '0) begin
            w_class = RES_ZERO;
        end else if (lzc_s1_q > w_shift) begin
            w_class = RES_DENORM;
        end else begin
            w_class = RES_NORMAL;
        end
    end

    always_comb begin
        valid_s1_d = valid_s1_q;
        mant_s1_d  = mant_s1_q;
        exp_s1_d   = exp_s1_q;
        lzc_s1_d   = lzc_s1_q;
        if (flush) begin
            valid_s1_d = 1'b0;
        end else if (w_en_s1) begin
            valid_s1_d = in_valid;
            if (in_valid) begin
                mant_s1_d = in_mant;
                exp_s1_d  = in_exp;
                lzc_s1_d  = w_lzc;
            end
        end
    end

    always_comb begin
        valid_s2_d  = valid_s2_q;
        mant_s2_d   = mant_s2_q;
        exp_s2_d    = exp_s2_q;
        zero_s2_d   = zero_s2_q;
        denorm_s2_d = denorm_s2_q;
        if (flush) begin
            valid_s2_d = 1'b0;
        end else if (w_en_s2) begin
            valid_s2_d = valid_s1_q;
            if (valid_s1_q) begin
                mant_s2_d   = w_shifted;
                zero_s2_d   = (w_class == RES_ZERO);
                denorm_s2_d = (w_class == RES_DENORM);
                exp_s2_d    = (w_class == RES_NORMAL) ? (exp_s1_q - EXP_W'(w_shift)) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_q  <= 1'b0;
            mant_s1_q   <= '0;
            exp_s1_q    <= '0;
            lzc_s1_q    <= '0;
            valid_s2_q  <= 1'b0;
            mant_s2_q   <= '0;
            exp_s2_q    <= '0;
            zero_s2_q   <= 1'b0;
            denorm_s2_q <= 1'b0;
        end else begin
            valid_s1_q  <= valid_s1_d;
            mant_s1_q   <= mant_s1_d;
            exp_s1_q    <= exp_s1_d;
            lzc_s1_q    <= lzc_s1_d;
            valid_s2_q  <= valid_s2_d;
            mant_s2_q   <= mant_s2_d;
            exp_s2_q    <= exp_s2_d;
            zero_s2_q   <= zero_s2_d;
            denorm_s2_q <= denorm_s2_d;
        end
    end

    assign out_valid  = valid_s2_q;
    assign out_mant   = mant_s2_q;
    assign out_exp    = exp_s2_q;
    assign out_zero   = zero_s2_q;
    assign out_denorm = denorm_s2_q;

endmodule

`default_nettype wire

// File: tb/tb_ul_normalizer.sv
// ============================================================================
// Module   : tb_ul_normalizer
// Brief    : Scoreboard bench for ul_normalizer with a behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ul_normalizer;

    typedef struct packed {
        logic [31:0] mant;
        logic [8:0]  exp;
        logic        zero;
        logic        denorm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mant;
    logic [8:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mant;
    logic [8:0]  out_exp;
    logic        out_zero;
    logic        out_denorm;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    int n_pop  = 0;
    int n_drop = 0;

    exp_t sb [$];
    exp_t mon_e;

    ul_normalizer #(.W(32), .EXP_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: normalise by counting zeros from the top, clamp at exponent 1.
    function automatic exp_t model(input logic [31:0] m, input logic [8:0] e);
        exp_t r;
        int lz = 0;
        int ei = int'(e);
        int sh;
        while (lz < 32 && m[31 - lz] == 1'b0) lz++;
        if (ei == 0)           sh = 0;
        else if (lz < ei - 1)  sh = lz;
        else                   sh = ei - 1;
        r.mant   = (m == 0) ? 32'd0 : (m << sh);
        r.zero   = (m == 0);
        r.denorm = (m != 0) && (lz > sh);
        r.exp    = (m == 0 || lz > sh) ? 9'd0 : 9'(ei - sh);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_mant 0x%0h required no item", out_mant);
            end else begin
                mon_e = sb.pop_front();
                n_pop++;
                chk("out_mant",   64'(out_mant),   64'(mon_e.mant));
                chk("out_exp",    64'(out_exp),    64'(mon_e.exp));
                chk("out_zero",   64'(out_zero),   64'(mon_e.zero));
                chk("out_denorm", 64'(out_denorm), 64'(mon_e.denorm));
            end
        end
    end

    // One cycle, entered and left at posedge+1; acceptance is judged at the negedge.
    task automatic step(input logic v, input logic [31:0] m, input logic [8:0] e,
                        input logic rdy, input exp_t ex, output logic acc);
        in_valid  = v;
        in_mant   = m;
        in_exp    = e;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready && !flush;
        if (acc) begin
            sb.push_back(ex);
            n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic put(input logic [31:0] m, input logic [8:0] e, input exp_t ex);
        logic acc;
        int   tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            step(1'b1, m, e, 1'b1, ex, acc);
            tries++;
        end
        chk("put_accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        logic acc;
        int   cnt = 0;
        while (sb.size() != 0 && cnt < 50) begin
            step(1'b0, 32'd0, 9'd0, 1'b1, '0, acc);
            cnt++;
        end
        step(1'b0, 32'd0, 9'd0, 1'b1, '0, acc);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] sm [4];
        logic [8:0]  se [4];
        logic [31:0] cap_m;
        logic [8:0]  cap_e;
        int          idx;
        int          k;
        int          cyc;
        logic [31:0] rm;
        logic [8:0]  re;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mant   = 32'd0;
        in_exp    = 9'd0;
        out_ready = 1'b0;

        #2;
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_mant",   64'(out_mant),   64'd0);
        chk("rst_out_exp",    64'(out_exp),    64'd0);
        chk("rst_out_zero",   64'(out_zero),   64'd0);
        chk("rst_out_denorm", 64'(out_denorm), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases with hand-derived results; also latency of the first one.
        put(32'h0000_0001, 9'd100, '{mant: 32'h8000_0000, exp: 9'd69, zero: 1'b0, denorm: 1'b0});
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        step(1'b0, 32'd0, 9'd0, 1'b1, '0, acc);
        put(32'h0001_0000, 9'd10,  '{mant: 32'h0200_0000, exp: 9'd0,  zero: 1'b0, denorm: 1'b1});
        put(32'h0000_0000, 9'd50,  '{mant: 32'h0000_0000, exp: 9'd0,  zero: 1'b1, denorm: 1'b0});
        put(32'h8000_0001, 9'd5,   '{mant: 32'h8000_0001, exp: 9'd5,  zero: 1'b0, denorm: 1'b0});
        put(32'h0000_00F0, 9'd0,   '{mant: 32'h0000_00F0, exp: 9'd0,  zero: 1'b0, denorm: 1'b1});
        put(32'h4000_0000, 9'd1,   '{mant: 32'h4000_0000, exp: 9'd0,  zero: 1'b0, denorm: 1'b1});
        put(32'h4000_0000, 9'd2,   '{mant: 32'h8000_0000, exp: 9'd1,  zero: 1'b0, denorm: 1'b0});
        drain();

        // Stall: four items offered back-to-back while the output is blocked.
        for (int i = 0; i < 4; i++) begin
            sm[i] = 32'h0000_0100 << (i * 3);
            se[i] = 9'(40 + i);
        end
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, sm[idx], se[idx], 1'b0, model(sm[idx], se[idx]), acc);
            if (acc) idx++;
            if (c == 2) begin
                cap_m = out_mant;
                cap_e = out_exp;
            end
        end
        chk("stall_accepted", 64'(idx), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_mant_stable", 64'(out_mant), 64'(cap_m));
        chk("stall_exp_stable", 64'(out_exp), 64'(cap_e));
        for (int c = 0; c < 4; c++) begin
            chk("no_gap_out_valid", 64'(out_valid), 64'd1);
            k = (idx < 4) ? idx : 3;
            step(idx < 4, sm[k], se[k], 1'b1, model(sm[k], se[k]), acc);
            if (acc) idx++;
        end
        chk("stall_all_accepted", 64'(idx), 64'd4);
        drain();

        // Random stream with random valid/ready against the reference.
        idx = 0;
        cyc = 0;
        while (idx < 10000 && cyc < 60000) begin
            rm = $urandom() >> $urandom_range(0, 32);
            if ($urandom_range(0, 15) == 0) rm = 32'd0;
            re = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 40)) : 9'($urandom());
            step($urandom_range(0, 3) != 0, rm, re, $urandom_range(0, 3) != 0, model(rm, re), acc);
            if (acc) idx++;
            cyc++;
        end
        chk("random_items_accepted", 64'(idx), 64'd10000);
        drain();

        // Flush with two items in flight and a new item offered on the flush cycle.
        step(1'b1, 32'h0000_1234, 9'd80, 1'b0, model(32'h0000_1234, 9'd80), acc);
        step(1'b1, 32'h0F00_0000, 9'd20, 1'b0, model(32'h0F00_0000, 9'd20), acc);
        flush = 1'b1;
        step(1'b1, 32'h0000_0077, 9'd60, 1'b0, model(32'h0000_0077, 9'd60), acc);
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        n_drop += sb.size();
        sb.delete();
        repeat (4) step(1'b0, 32'd0, 9'd0, 1'b1, '0, acc);
        chk("flush_no_stale", 64'(out_valid), 64'd0);

        // Asynchronous reset with two items in flight.
        step(1'b1, 32'h0000_0ABC, 9'd70, 1'b0, model(32'h0000_0ABC, 9'd70), acc);
        step(1'b1, 32'h00C0_0000, 9'd30, 1'b0, model(32'h00C0_0000, 9'd30), acc);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_mant", 64'(out_mant), 64'd0);
        n_drop += sb.size();
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) step(1'b0, 32'd0, 9'd0, 1'b1, '0, acc);
        chk("arst_no_stale", 64'(out_valid), 64'd0);

        put(32'h0000_0003, 9'd200, model(32'h0000_0003, 9'd200));
        drain();
        chk("item_count", 64'(n_pop), 64'(n_acc - n_drop));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
